// File: rtl/data_mem_responder.sv
// 4 KiB data memory for a CPU M-stage with zero-latency reads, byte-lane writes
// and a FIFO of write-trace records for an external monitor.
module data_mem_responder #(
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_byteen,
  output logic [7:0]  trace_drop_cnt,
  output logic        trace_ovf,
  output logic        addr_err
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(TRACE_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } trace_rec_t;

  logic [31:0] mem [1024];
  logic [9:0]  word_idx;
  logic        in_range;
  logic [31:0] cur_word;
  logic [31:0] merged_word;
  logic        wr_accept;
  logic        unused_addr_bits;

  assign in_range         = (m_data_addr[31:12] == 20'd0);
  assign word_idx         = m_data_addr[11:2];
  assign cur_word         = mem[word_idx];
  assign m_data_rdata     = in_range ? cur_word : 32'd0;
  assign wr_accept        = in_range && (m_data_byteen != 4'b0000);
  assign unused_addr_bits = ^m_data_addr[1:0];

  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) merged_word[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  // NOTE: the memory is cleared by reset, so it cannot map onto a plain RAM
  // macro; it must be built from flops since every word has to read back 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    end else if (wr_accept) begin
      // NOTE: non-blocking update keeps the pre-edge word visible to the read
      // path for the whole write cycle.
      mem[word_idx] <= merged_word;
    end
  end

  // Trace FIFO: storage is never reset; outputs are gated by occupancy instead.
  trace_rec_t       fifo [TRACE_DEPTH];
  trace_rec_t       head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign fifo_full   = (count == DEPTH_CNT);
  assign trace_valid = (count != '0);
  assign pop         = trace_valid && trace_ready;
  assign push_ok     = wr_accept && (!fifo_full || pop);
  assign drop        = wr_accept && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo[wr_ptr] <= '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00},
                        data: merged_word, byteen: m_data_byteen};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      trace_drop_cnt <= 8'd0;
      trace_ovf      <= 1'b0;
      addr_err       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        trace_ovf <= 1'b1;
        if (trace_drop_cnt != 8'hFF) trace_drop_cnt <= trace_drop_cnt + 8'd1;
      end
      if (!in_range) addr_err <= 1'b1;
    end
  end

  assign head         = fifo[rd_ptr];
  assign trace_pc     = trace_valid ? head.pc     : 32'd0;
  assign trace_addr   = trace_valid ? head.addr   : 32'd0;
  assign trace_data   = trace_valid ? head.data   : 32'd0;
  assign trace_byteen = trace_valid ? head.byteen : 4'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// random traffic, all compared against a word-array / record-queue model.
module tb_data_mem_responder;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_byteen;
  logic [7:0]  trace_drop_cnt;
  logic        trace_ovf;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [31:0] mdl_mem [1024];
  rec_t        mdl_q [$];
  int          mdl_drop;
  bit          mdl_ovf;
  bit          mdl_aerr;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  data_mem_responder #(.TRACE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_inst_addr    (m_inst_addr),
    .m_data_rdata   (m_data_rdata),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_byteen   (trace_byteen),
    .trace_drop_cnt (trace_drop_cnt),
    .trace_ovf      (trace_ovf),
    .addr_err       (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (a >= 32'h1000) return 32'd0;
    return mdl_mem[a / 4];
  endfunction

  function automatic logic [31:0] mdl_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                            input logic [3:0] be);
    logic [31:0] res = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // One clock: drive, compare pre-edge outputs to the model, clock, advance the model.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic rdy, input bit do_chk = 1'b1);
    rec_t exp_head;
    bit   in_rng;
    bit   pop;
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    trace_ready   = rdy;
    m_inst_addr   = pc_ctr;
    #2;
    if (do_chk) begin
      exp_head = (mdl_q.size() != 0) ? mdl_q[0] : '0;
      check("rdata",    m_data_rdata,   mdl_read(a));
      check("valid",    trace_valid,    32'(mdl_q.size() != 0));
      check("tr_pc",    trace_pc,       exp_head.pc);
      check("tr_addr",  trace_addr,     exp_head.addr);
      check("tr_data",  trace_data,     exp_head.data);
      check("tr_be",    trace_byteen,   32'(exp_head.byteen));
      check("drop_cnt", trace_drop_cnt, 32'(mdl_drop));
      check("ovf",      trace_ovf,      32'(mdl_ovf));
      check("addr_err", addr_err,       32'(mdl_aerr));
    end
    @(posedge clk);
    if (reset) begin
      for (int w = 0; w < 1024; w++) mdl_mem[w] = 32'd0;
      mdl_q.delete();
      mdl_drop = 0;
      mdl_ovf  = 1'b0;
      mdl_aerr = 1'b0;
    end else begin
      in_rng = (a < 32'h1000);
      pop    = (mdl_q.size() != 0) && rdy;
      if (!in_rng) mdl_aerr = 1'b1;
      if (pop) void'(mdl_q.pop_front());
      if (in_rng && be != 4'b0000) begin
        mdl_mem[a / 4] = mdl_merge(mdl_mem[a / 4], wd, be);
        if (mdl_q.size() < DEPTH) begin
          mdl_q.push_back('{pc: pc_ctr, addr: a & ~32'd3, data: mdl_mem[a / 4], byteen: be});
        end else begin
          mdl_ovf = 1'b1;
          if (mdl_drop < 255) mdl_drop++;
        end
      end
    end
    pc_ctr += 4;
    #1;
  endtask

  task automatic do_reset(input bit do_chk);
    reset = 1'b1;
    cycle(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1, do_chk);  // coincident write must be lost
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < DEPTH + 2; n++) cycle(32'h0, 32'h0, 4'h0, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    do_reset(1'b0);

    // Reset state
    for (int k = 0; k < 4; k++) cycle(32'(k * 32'h3F0), 32'h0, 4'h0, 1'b0);
    check("rst_rd_0x40", m_data_rdata, 32'd0);

    // Byte-lane writes
    trace_ready = 1'b0;
    cycle(32'h10, 32'h1122_3344, 4'b1111, 1'b0);
    cycle(32'h12, 32'h00AA_0000, 4'b0100, 1'b0);
    cycle(32'h10, 32'h0, 4'h0, 1'b1);
    check("lane_rd_0x10", m_data_rdata, 32'h11AA_3344);
    check("lane_rec1_data", trace_data, 32'h11AA_3344);
    check("lane_rec1_addr", trace_addr, 32'h10);
    check("lane_rec1_be",   trace_byteen, 32'(4'b0100));
    drain();

    // Read-during-write
    cycle(32'h20, 32'd5, 4'hF, 1'b1);
    cycle(32'h20, 32'd9, 4'hF, 1'b1);
    cycle(32'h20, 32'd0, 4'h0, 1'b1);
    check("rdw_after", m_data_rdata, 32'd9);
    drain();

    // Overflow: 10 writes with no pops
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) cycle(32'(32'h100 + 4 * k), 32'(32'hA000 + k), 4'hF, 1'b0);
    cycle(32'h0, 32'h0, 4'h0, 1'b0);
    check("ovf_valid", trace_valid, 32'd1);
    check("ovf_drop",  trace_drop_cnt, 32'd2);
    check("ovf_flag",  trace_ovf, 32'd1);
    check("ovf_head",  trace_data, 32'hA000);

    // Full FIFO with simultaneous push and pop
    cycle(32'h200, 32'h5555_AAAA, 4'hF, 1'b1);
    cycle(32'h0, 32'h0, 4'h0, 1'b0);
    check("fullpp_drop", trace_drop_cnt, 32'd2);
    check("fullpp_head", trace_data, 32'hA001);
    drain();

    // Out-of-range write
    cycle(32'h0000_3000, 32'hCAFE_F00D, 4'hF, 1'b1);
    cycle(32'h0000_3000, 32'h0, 4'h0, 1'b1);
    check("oor_err",   addr_err, 32'd1);
    check("oor_rdata", m_data_rdata, 32'd0);
    check("oor_nopush", trace_valid, 32'd0);
    cycle(32'h0, 32'h0, 4'h0, 1'b1);

    // Reset mid-operation
    cycle(32'h0, 32'hFFFF_FFFF, 4'hF, 1'b0);
    cycle(32'h4, 32'h1, 4'h1, 1'b0);
    cycle(32'h8, 32'h2, 4'h2, 1'b0);
    do_reset(1'b1);
    cycle(32'h0, 32'h0, 4'h0, 1'b0);
    check("mid_rst_rd0",   m_data_rdata, 32'd0);
    check("mid_rst_valid", trace_valid, 32'd0);
    check("mid_rst_drop",  trace_drop_cnt, 32'd0);
    check("mid_rst_flags", {trace_ovf, addr_err}, 32'd0);
    cycle(32'h40, 32'h0, 4'h0, 1'b0);

    // Random traffic on a small address window to force reuse and overflow
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      cycle(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 149) == 0) do_reset(1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `m_data_addr`, input, 32 bits: CPU M-stage byte address.
REQ-004 SHALL have `m_data_wdata`, input, 32 bits: write data, already lane-aligned by the CPU.
REQ-005 SHALL have `m_data_byteen`, input, 4 bits: byte write enables; 4'b0000 means a read or idle cycle.
REQ-006 SHALL have `m_inst_addr`, input, 32 bits: M-stage PC, used only for tracing.
REQ-007 SHALL have `m_data_rdata`, output, 32 bits: read word at the word containing `m_data_addr`.
REQ-008 SHALL have `trace_valid`, output, 1 bit: the trace FIFO head is valid.
REQ-009 SHALL have `trace_ready`, input, 1 bit: the monitor accepts the head.
REQ-010 SHALL have `trace_pc`, `trace_addr` and `trace_data`, all outputs of 32 bits, plus `trace_byteen`, output, 4 bits: the head record.
REQ-011 SHALL have `trace_drop_cnt`, output, 8 bits: count of records lost to overflow.
REQ-012 SHALL have `trace_ovf`, output, 1 bit: sticky overflow flag.
REQ-013 SHALL have `addr_err`, output, 1 bit: sticky out-of-range access flag.
REQ-014 SHALL have parameter `TRACE_DEPTH`, default 8, power of two >= 2: trace FIFO entries.

Function
REQ-015 SHALL store 1024 words of 32 bits (4 KiB), indexed by `m_data_addr[11:2]`.
REQ-016 SHALL treat any address with `m_data_addr[31:12]` != 0 as out of range.
REQ-017 SHALL drive `m_data_rdata` combinationally from the addressed word, with zero latency, regardless of `m_data_byteen`.
REQ-018 SHALL drive `m_data_rdata` = 0 for out-of-range addresses.
REQ-019 SHALL, on a rising edge with `m_data_byteen` != 0 and the address in range, replace exactly those bytes i whose `m_data_byteen[i]` = 1 with `m_data_wdata[8i+7:8i]`; all other bytes are unchanged.
REQ-020 SHALL, on a read-during-write to the same word, return the pre-edge contents on `m_data_rdata` in that cycle.
REQ-021 SHALL ignore an out-of-range write (memory unchanged, no trace push) and SHALL set `addr_err` on that edge.
REQ-022 SHALL also set `addr_err` on an out-of-range read (byteen = 0) at the edge.
REQ-023 SHALL, for every accepted write, push one record into the trace FIFO: `trace_pc` = `m_inst_addr`, `trace_addr` = {`m_data_addr[31:2]`, 2'b00}, `trace_data` = full merged word after the write, `trace_byteen` = `m_data_byteen`.
REQ-024 SHALL pop the FIFO on an edge where `trace_valid` && `trace_ready`.
REQ-025 SHALL hold the head record stable while `trace_valid` && !`trace_ready`.
REQ-026 SHALL keep records in FIFO order; read and write pointers wrap modulo `TRACE_DEPTH`.
REQ-027 SHALL drive all `trace_*` data outputs to 0 when the FIFO is empty (`trace_valid` = 0).
REQ-028 SHALL, on a push into an empty FIFO, assert `trace_valid` from the following cycle (one-cycle latency).
REQ-029 SHALL, on a push when full and no pop on the same edge, drop the new record, set `trace_ovf`, and increment `trace_drop_cnt`, saturating at 255.
REQ-030 SHALL, on a push when full with a pop on the same edge, accept the push; occupancy is unchanged and nothing is dropped.
REQ-031 SHALL, on a pop from an empty FIFO, take no action.
REQ-032 SHALL, on a simultaneous push and pop when occupancy is 1, keep `trace_valid` = 1 and present the new record next cycle.

Reset
REQ-033 SHALL, on `reset` = 1 at an edge, clear all 1024 words to 0, empty the FIFO, and clear `trace_drop_cnt`, `trace_ovf` and `addr_err`.
REQ-034 SHALL give reset priority over any write, push or pop on the same edge; a write coincident with reset is lost.
REQ-035 SHALL hold the following values after reset: `trace_valid` = 0, all `trace_*` data = 0, `m_data_rdata` = 0 for any address.

Verification
REQ-036 SHALL cover byte-lane writes:
- stimulus: write addr 0x10, byteen 4'b1111, data 0x11223344; then write addr 0x12, byteen 4'b0100, data 0x00AA0000.
- response: read 0x10 gives 0x11AA3344; the second trace record is {pc, 0x10, 0x11AA3344, 4'b0100}.
REQ-037 SHALL cover read-during-write:
- stimulus: word 0x20 holds 5; write 9 to 0x20.
- response: `m_data_rdata` = 5 in the write cycle and 9 in the next cycle.
REQ-038 SHALL cover overflow:
- stimulus: `trace_ready` = 0; 10 consecutive accepted writes.
- response: `trace_valid` = 1, 8 records retained in order, `trace_drop_cnt` = 2, `trace_ovf` = 1.
REQ-039 SHALL cover a full FIFO with simultaneous push and pop:
- stimulus: full FIFO, `trace_ready` = 1 and a write on the same edge.
- response: the oldest record leaves, the new record is appended, `trace_drop_cnt` is unchanged.
REQ-040 SHALL cover out-of-range access:
- stimulus: write to 0x00003000 with byteen 4'b1111.
- response: no memory change, no trace push, `addr_err` = 1, `m_data_rdata` = 0.
REQ-041 SHALL cover reset mid-operation:
- stimulus: FIFO holding 3 records and word 0x0 = 0xFFFFFFFF; assert `reset` for one edge.
- response: `trace_valid` = 0, read of 0x0 gives 0, counters and flags = 0.
